video_pattern_gen: RTL and testbench
====================================

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 SHALL have parameters: RGB_WIDTH, default 24, pixel width, multiple of 3; component width CW = RGB_WIDTH/3.
REQ-002 SHALL have parameters: H_ACTIVE, default 480, visible pixels per line.
REQ-003 SHALL have parameters: H_FP 2, H_SYNC 41, H_BP 2, horizontal front porch, sync and back porch in clocks; H_TOTAL = sum of all four H parameters.
REQ-004 SHALL have parameters: V_ACTIVE 272, V_FP 2, V_SYNC 10, V_BP 2, vertical equivalents in lines; V_TOTAL = sum of all four V parameters.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset; synchronous, active-low.
- i_enable  in  1  run request.
- i_pattern_sel  in  2  0 solid, 1 colour bars, 2 gradient, 3 checkerboard.
- i_solid_rgb  in  RGB_WIDTH  colour for pattern 0.
- o_video_rgb  out  RGB_WIDTH  pixel data; feeds i_video_rgb of axi_pmod_tft.
- o_video_h_sync  out  1  active-high horizontal sync.
- o_video_v_sync  out  1  active-high vertical sync.
- o_video_data_en  out  1  pixel valid.
- o_video_hblank  out  1  horizontal blanking.
- o_video_vblank  out  1  vertical blanking.
- o_frame_start  out  1  one-cycle pulse on the first pixel of each frame.
- o_frame_count  out  16  frames started since reset.

Function
REQ-006 SHALL hold h_count (0..H_TOTAL-1) and v_count (0..V_TOTAL-1). h_count increments every running clock; at H_TOTAL-1 it wraps to 0 and v_count increments; v_count wraps to 0 after V_TOTAL-1.
REQ-007 SHALL implement two states:
- IDLE: counters held at 0, all outputs 0.
- RUN: counters advance per REQ-006.
REQ-008 SHALL move IDLE->RUN on the clock edge where i_enable is sampled 1. The first RUN cycle has the counters at (0,0).
REQ-009 SHALL sample i_enable in RUN only at position (H_TOTAL-1, V_TOTAL-1). If it is 0 there, SHALL go to IDLE instead of wrapping. Deassertion mid-frame SHALL NOT truncate the frame.
REQ-010 SHALL latch i_pattern_sel and i_solid_rgb when entering (0,0), whether from IDLE or by wrap. Latched values hold for the whole frame.
REQ-011 SHALL register all video outputs. Outputs SHALL reflect the counter position of the previous clock, giving one clock of latency from counter to output.
REQ-012 SHALL drive the flags as follows:
- hblank = (h >= H_ACTIVE); vblank = (v >= V_ACTIVE).
- data_en = !hblank && !vblank.
- h_sync = 1 for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
- v_sync = 1 for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for the whole line width.
REQ-013 SHALL force o_video_rgb to 0 whenever data_en is 0.
REQ-014 SHALL generate pattern 1 as 8 bars of width BW = H_ACTIVE/8 (integer division). Bar index = min(h/BW, 7). Colour order: white, yellow, cyan, green, magenta, red, blue, black. Full-scale component = all ones, R in the MSBs.
REQ-015 SHALL generate pattern 2 with R=G=B = h_count[CW-1:0], so the ramp wraps every 2^CW pixels.
REQ-016 SHALL generate pattern 3 as white when h_count[3] XOR v_count[3] is 1, else black.
REQ-017 SHALL pulse o_frame_start exactly on the output cycle of position (0,0). o_frame_count SHALL increment on the same cycle, wrapping from 0xFFFF to 0.

Reset
REQ-018 SHALL, on a clock edge with rst_n=0: enter IDLE, clear counters, clear o_frame_count, and drive every output to 0. This SHALL apply mid-frame as well, with no partial-frame completion.
REQ-019 SHALL, on the first edge with rst_n=1, re-evaluate i_enable per REQ-008.

Verification
Bench parameters: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); RGB_WIDTH=24.
REQ-020 SHALL verify start-up timing: i_enable=1 after reset -> o_frame_start and o_video_data_en rise on the 2nd edge after enable is sampled. data_en is high for 16 clocks, then h_sync is high for output clocks 18-20 of the line.
REQ-021 SHALL verify pattern 1: each bar is 2 pixels. Output pixels 0-1 = 0xFFFFFF, pixels 2-3 = 0xFFFF00, pixels 14-15 = 0x000000. rgb = 0 during hblank.
REQ-022 SHALL verify frame structure and pattern 0: with i_solid_rgb=0x123456, 4 lines of 16 active pixels of 0x123456. v_sync is high for lines 5-6 (48 clocks). The next o_frame_start comes exactly 192 clocks later.
REQ-023 SHALL verify mid-frame controls: i_enable dropped and i_pattern_sel changed 0->3 mid-frame -> the current frame completes unchanged with pattern 0, then all outputs are 0 and o_frame_count stops. Re-enable starts a checkerboard frame.
REQ-024 SHALL verify reset: rst_n=0 mid-frame -> all outputs 0 on the next edge, o_frame_count=0. After release with i_enable=1, a full frame restarts from (0,0).
REQ-025 SHALL verify counter wrap: o_frame_count forced or run to 0xFFFF -> the next o_frame_start sets it to 0x0000.

Source files
------------

// File: rtl/video_pattern_gen.sv
// Free-running video timing generator with four selectable test patterns.
// Sync, blanking and pixel outputs are registered and lag the counters by one clock.
module video_pattern_gen #(
  parameter int RGB_WIDTH = 24,
  parameter int H_ACTIVE  = 480,
  parameter int H_FP      = 2,
  parameter int H_SYNC    = 41,
  parameter int H_BP      = 2,
  parameter int V_ACTIVE  = 272,
  parameter int V_FP      = 2,
  parameter int V_SYNC    = 10,
  parameter int V_BP      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_enable,
  input  logic [1:0]           i_pattern_sel,
  input  logic [RGB_WIDTH-1:0] i_solid_rgb,
  output logic [RGB_WIDTH-1:0] o_video_rgb,
  output logic                 o_video_h_sync,
  output logic                 o_video_v_sync,
  output logic                 o_video_data_en,
  output logic                 o_video_hblank,
  output logic                 o_video_vblank,
  output logic                 o_frame_start,
  output logic [15:0]          o_frame_count
);

  localparam int CW      = RGB_WIDTH / 3;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BW      = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [HW-1:0]        h_count;
  logic [VW-1:0]        v_count;
  logic [1:0]           pat_q;
  logic [RGB_WIDTH-1:0] solid_q;

  logic [31:0]          h32, v32, bar;
  logic [2:0]           bar_bits;
  logic                 hb, vb, hs, vs, de, at_origin;
  logic [RGB_WIDTH-1:0] pix;

  always_comb begin
    h32       = 32'(h_count);
    v32       = 32'(v_count);
    hb        = h32 >= H_ACTIVE;
    vb        = v32 >= V_ACTIVE;
    de        = !hb && !vb;
    hs        = (h32 >= H_ACTIVE + H_FP) && (h32 < H_ACTIVE + H_FP + H_SYNC);
    vs        = (v32 >= V_ACTIVE + V_FP) && (v32 < V_ACTIVE + V_FP + V_SYNC);
    at_origin = (h32 == 32'd0) && (v32 == 32'd0);
    bar       = h32 / BW;
    if (bar > 32'd7) bar = 32'd7;
    // Bar bits are {R,G,B} on/off: white, yellow, cyan, green, magenta, red, blue, black
    case (bar[2:0])
      3'd0:    bar_bits = 3'b111;
      3'd1:    bar_bits = 3'b110;
      3'd2:    bar_bits = 3'b011;
      3'd3:    bar_bits = 3'b010;
      3'd4:    bar_bits = 3'b101;
      3'd5:    bar_bits = 3'b100;
      3'd6:    bar_bits = 3'b001;
      default: bar_bits = 3'b000;
    endcase
    pix = '0;
    case (pat_q)
      2'd0:    pix = solid_q;
      2'd1:    pix = {{CW{bar_bits[2]}}, {CW{bar_bits[1]}}, {CW{bar_bits[0]}}};
      2'd2:    pix = {3{h32[CW-1:0]}};
      default: pix = (h32[3] ^ v32[3]) ? '1 : '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      h_count         <= '0;
      v_count         <= '0;
      pat_q           <= '0;
      solid_q         <= '0;
      o_video_rgb     <= '0;
      o_video_h_sync  <= 1'b0;
      o_video_v_sync  <= 1'b0;
      o_video_data_en <= 1'b0;
      o_video_hblank  <= 1'b0;
      o_video_vblank  <= 1'b0;
      o_frame_start   <= 1'b0;
      o_frame_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          h_count         <= '0;
          v_count         <= '0;
          o_video_rgb     <= '0;
          o_video_h_sync  <= 1'b0;
          o_video_v_sync  <= 1'b0;
          o_video_data_en <= 1'b0;
          o_video_hblank  <= 1'b0;
          o_video_vblank  <= 1'b0;
          o_frame_start   <= 1'b0;
          if (i_enable) begin
            state   <= RUN;
            pat_q   <= i_pattern_sel;
            solid_q <= i_solid_rgb;
          end
        end
        default: begin
          o_video_rgb     <= de ? pix : '0;
          o_video_h_sync  <= hs;
          o_video_v_sync  <= vs;
          o_video_data_en <= de;
          o_video_hblank  <= hb;
          o_video_vblank  <= vb;
          o_frame_start   <= at_origin;
          if (at_origin) o_frame_count <= o_frame_count + 16'd1;
          // Enable is only honoured at the last position so frames are never truncated
          if (h32 == H_TOTAL - 1) begin
            h_count <= '0;
            if (v32 == V_TOTAL - 1) begin
              v_count <= '0;
              if (i_enable) begin
                pat_q   <= i_pattern_sel;
                solid_q <= i_solid_rgb;
              end else begin
                state <= IDLE;
              end
            end else begin
              v_count <= v_count + 1'b1;
            end
          end else begin
            h_count <= h_count + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: directed timing checks plus randomized pattern/enable
// traffic compared every clock against a frame-position reference model.
module tb_video_pattern_gen;

  localparam int HA = 16, HF = 2, HS = 3, HBP = 3;
  localparam int VA = 4,  VF = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HF + HS + HBP;
  localparam int VT = VA + VF + VS + VBP;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic [1:0]  i_pattern_sel = 2'd0;
  logic [23:0] i_solid_rgb = 24'd0;
  logic [23:0] o_video_rgb;
  logic        o_video_h_sync, o_video_v_sync, o_video_data_en;
  logic        o_video_hblank, o_video_vblank, o_frame_start;
  logic [15:0] o_frame_count;

  int errors = 0;
  int checks = 0;

  // Reference model state: a linear position inside the frame
  bit          m_run = 1'b0;
  int          m_pos = 0;
  logic [1:0]  m_pat = 2'd0;
  logic [23:0] m_solid = 24'd0;
  logic [15:0] m_fc = 16'd0;
  logic [23:0] e_rgb;
  logic        e_hs, e_vs, e_de, e_hb, e_vb, e_fs;

  logic [23:0] bar_colour [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  video_pattern_gen #(
    .RGB_WIDTH(24), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_pattern_sel(i_pattern_sel),
    .i_solid_rgb(i_solid_rgb), .o_video_rgb(o_video_rgb), .o_video_h_sync(o_video_h_sync),
    .o_video_v_sync(o_video_v_sync), .o_video_data_en(o_video_data_en),
    .o_video_hblank(o_video_hblank), .o_video_vblank(o_video_vblank),
    .o_frame_start(o_frame_start), .o_frame_count(o_frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ref_pixel(input int h, input int v, input logic [1:0] pat,
                                            input logic [23:0] solid);
    int b;
    case (pat)
      2'd0: return solid;
      2'd1: begin b = h / (HA / 8); if (b > 7) b = 7; return bar_colour[b]; end
      2'd2: return 24'((h % 256) * 32'h010101);
      default: return ((((h / 8) % 2) ^ ((v / 8) % 2)) != 0) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // Predict the outputs of the coming edge from the current inputs, then check them
  task automatic step();
    int h, v;
    e_rgb = '0; e_hs = 0; e_vs = 0; e_de = 0; e_hb = 0; e_vb = 0; e_fs = 0;
    if (!rst_n) begin
      m_fc = 16'd0; m_run = 1'b0; m_pos = 0;
    end else if (!m_run) begin
      if (i_enable) begin
        m_run = 1'b1; m_pos = 0; m_pat = i_pattern_sel; m_solid = i_solid_rgb;
      end
    end else begin
      h = m_pos % HT;
      v = m_pos / HT;
      e_hb = (h >= HA);
      e_vb = (v >= VA);
      e_de = !e_hb && !e_vb;
      e_hs = (h >= HA + HF) && (h < HA + HF + HS);
      e_vs = (v >= VA + VF) && (v < VA + VF + VS);
      e_fs = (m_pos == 0);
      if (m_pos == 0) m_fc = m_fc + 16'd1;
      e_rgb = e_de ? ref_pixel(h, v, m_pat, m_solid) : 24'd0;
      if (m_pos == FRAME - 1) begin
        m_pos = 0;
        if (i_enable) begin m_pat = i_pattern_sel; m_solid = i_solid_rgb; end
        else m_run = 1'b0;
      end else begin
        m_pos++;
      end
    end
    @(posedge clk);
    #1;
    chk("rgb", 32'(o_video_rgb), 32'(e_rgb));
    chk("h_sync", 32'(o_video_h_sync), 32'(e_hs));
    chk("v_sync", 32'(o_video_v_sync), 32'(e_vs));
    chk("data_en", 32'(o_video_data_en), 32'(e_de));
    chk("hblank", 32'(o_video_hblank), 32'(e_hb));
    chk("vblank", 32'(o_video_vblank), 32'(e_vb));
    chk("frame_start", 32'(o_frame_start), 32'(e_fs));
    chk("frame_count", 32'(o_frame_count), 32'(m_fc));
  endtask

  initial begin
    int n, de_cnt, vs_cnt, bad;

    // Reset state
    for (int i = 0; i < 3; i++) step();
    chk("reset_fc", 32'(o_frame_count), 32'd0);
    chk("reset_de", 32'(o_video_data_en), 32'd0);

    // Start-up timing and colour bars
    rst_n = 1'b1; i_enable = 1'b1; i_pattern_sel = 2'd1;
    step();
    chk("start_sample_fs", 32'(o_frame_start), 32'd0);
    for (int i = 0; i < HT; i++) begin
      step();
      if (i == 0) chk("first_fs", 32'(o_frame_start), 32'd1);
      if (i == 0) chk("first_de", 32'(o_video_data_en), 32'd1);
      if (i == 0 || i == 1) chk("bar_white", 32'(o_video_rgb), 32'hFFFFFF);
      if (i == 2 || i == 3) chk("bar_yellow", 32'(o_video_rgb), 32'hFFFF00);
      if (i == 14 || i == 15) chk("bar_black", 32'(o_video_rgb), 32'h000000);
      if (i == 16) chk("hblank_rgb", 32'(o_video_rgb), 32'h0);
      chk("line_de", 32'(o_video_data_en), 32'(i < 16));
      chk("line_hsync", 32'(o_video_h_sync), 32'(i >= 18 && i <= 20));
    end

    // Solid colour frame: structure and period
    i_pattern_sel = 2'd0; i_solid_rgb = 24'h123456;
    n = 0;
    while (!o_frame_start && n < 2 * FRAME) begin step(); n++; end
    chk("fs_found", 32'(o_frame_start), 32'd1);
    n = 0; de_cnt = 0; vs_cnt = 0; bad = 0;
    do begin
      if (o_video_data_en) begin
        de_cnt++;
        if (o_video_rgb !== 24'h123456) bad++;
      end
      if (o_video_v_sync) vs_cnt++;
      step();
      n++;
    end while (!o_frame_start && n < 2 * FRAME);
    chk("frame_period", 32'(n), 32'd192);
    chk("frame_de_count", 32'(de_cnt), 32'd64);
    chk("frame_vsync_count", 32'(vs_cnt), 32'd48);
    chk("solid_pixels_bad", 32'(bad), 32'd0);
    chk("fc_after_two", 32'(o_frame_count), 32'd3);

    // Mid-frame disable and pattern change
    for (int i = 0; i < 50; i++) step();
    i_enable = 1'b0; i_pattern_sel = 2'd3;
    for (int i = 0; i < FRAME; i++) step();
    chk("stopped_de", 32'(o_video_data_en), 32'd0);
    chk("stopped_vblank", 32'(o_video_vblank), 32'd0);
    chk("stopped_fc", 32'(o_frame_count), 32'd3);
    i_enable = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("checker_white", 32'(o_video_rgb), 32'hFFFFFF);
    chk("checker_fc", 32'(o_frame_count), 32'd4);

    // Mid-frame reset
    for (int i = 0; i < 60; i++) step();
    rst_n = 1'b0;
    step();
    chk("rst_rgb", 32'(o_video_rgb), 32'd0);
    chk("rst_hblank", 32'(o_video_hblank), 32'd0);
    chk("rst_fc", 32'(o_frame_count), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("restart_fs", 32'(o_frame_start), 32'd1);
    chk("restart_fc", 32'(o_frame_count), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      i_pattern_sel = 2'($urandom);
      if ($urandom_range(0, 7) == 0) i_solid_rgb = 24'($urandom);
      i_enable = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 799) != 0);
      step();
    end
    rst_n = 1'b1;

    // Frame counter wrap
    i_enable = 1'b0;
    n = 0;
    while (m_run && n < 2 * FRAME) begin step(); n++; end
    step();
    force dut.o_frame_count = 16'hFFFF;
    m_fc = 16'hFFFF;
    step();
    release dut.o_frame_count;
    step();
    chk("fc_preset", 32'(o_frame_count), 32'hFFFF);
    i_enable = 1'b1; i_pattern_sel = 2'd2;
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) chk("wrap_fc", 32'(o_frame_count), 32'h0000);
      if (i == 7) chk("gradient_px7", 32'(o_video_rgb), 32'h070707);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
